// File: rtl/bc_polinomio_pkg.sv
// Shared definitions for the polynomial control block (BC) and its datapath (BO):
// FSM state encodings, mux select constants, ALU mode constants and the
// width of the hold counter.
package bc_polinomio_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADX = 3'd1,
    MUL_A = 3'd2,
    ADD_B = 3'd3,
    MUL_X = 3'd4,
    ADD_C = 3'd5,
    DONE  = 3'd6
  } bcState_t;

  typedef logic [1:0] sel_t;

  // M0: constant operand select
  localparam sel_t M0_NONE = 2'b00;
  localparam sel_t M0_A    = 2'b01;
  localparam sel_t M0_B    = 2'b10;
  localparam sel_t M0_C    = 2'b11;

  // M1: ALU operand 1
  localparam sel_t M1_M0 = 2'b00;
  localparam sel_t M1_R0 = 2'b01;
  localparam sel_t M1_R1 = 2'b10;
  localparam sel_t M1_R2 = 2'b11;

  // M2: ALU operand 2
  localparam sel_t M2_R0 = 2'b00;
  localparam sel_t M2_M0 = 2'b01;
  localparam sel_t M2_R1 = 2'b10;
  localparam sel_t M2_R2 = 2'b11;

  // ALU mode
  localparam logic H_MUL = 1'b1;
  localparam logic H_ADD = 1'b0;

  // Hold counter width; covers OP_CYCLES up to 15
  localparam int CNT_W = 4;

endpackage

// File: rtl/bc_polinomio_if.sv
// Control bundle between the top level / BO and the polynomial control block.
// master = the control block (drives selects, strobes, busy/done).
// slave  = the side issuing start and consuming the sequencing outputs.
// The step input exists only when BC_STEP_EN is defined.
interface bc_polinomio_if;
  import bc_polinomio_pkg::*;

  logic start;
  logic busy;
  logic done;
  logic LX;
  logic LH;
  logic LS;
  logic H;
  sel_t M0;
  sel_t M1;
  sel_t M2;
`ifdef BC_STEP_EN
  logic step;
`endif

  modport master (
`ifdef BC_STEP_EN
    input  step,
`endif
    input  start,
    output busy, done, LX, LH, LS, H, M0, M1, M2
  );

  modport slave (
`ifdef BC_STEP_EN
    output step,
`endif
    output start,
    input  busy, done, LX, LH, LS, H, M0, M1, M2
  );

endinterface

// File: rtl/bc_polinomio_contador.sv
// bc_contador: loadable down-counter with a zero flag. Loaded with
// OP_CYCLES-1 on entry to an arithmetic state; zero marks the last hold cycle.
// It parks at zero rather than wrapping so a stalled state stays "last cycle".
module bc_contador
  import bc_polinomio_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] cntQ;

  // Reload on request, otherwise count down and stop at zero
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cntQ <= '0;
    end else if (load) begin
      cntQ <= loadVal;
    end else if (cntQ != '0) begin
      cntQ <= cntQ - W'(1);
    end
  end

  assign zero = (cntQ == '0);

endmodule

// File: rtl/bc_polinomio.sv
// bc_polinomio: Moore control block sequencing the BO datapath to evaluate
// y = ((A*x)+B)*x + C. Each arithmetic state is held OP_CYCLES cycles with
// its load strobe only in the final cycle; result lands in R2, then done.
// Optional macro BC_STEP_EN adds a step input that gates every transition
// out of LOADX and the arithmetic states (single-step debug).
module bc_polinomio
  import bc_polinomio_pkg::*;
#(
  parameter int OP_CYCLES = 1
) (
  input logic            clk,
  input logic            RST,
  bc_polinomio_if.master bus
);

  if (OP_CYCLES < 1 || OP_CYCLES > 15) begin : gBadOpCycles
    $error("bc_polinomio: OP_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(OP_CYCLES - 1);

  bcState_t stateQ;
  bcState_t stateD;
  logic     cntLoad;
  logic     holdDone;
  logic     stepOk;

  logic busyD;
  logic doneD;
  logic loadX;
  logic loadH;
  logic loadS;
  logic hMode;
  sel_t sel0;
  sel_t sel1;
  sel_t sel2;

`ifdef BC_STEP_EN
  assign stepOk = bus.step;
`else
  assign stepOk = 1'b1;
`endif

  bc_contador #(.W(CNT_W)) uHold (
    .clk     (clk),
    .RST     (RST),
    .load    (cntLoad),
    .loadVal (HOLD_RELOAD),
    .zero    (holdDone)
  );

  // State register
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state and output decode; outputs depend on stateQ (and step), never on start
  always_comb begin
    stateD  = stateQ;
    cntLoad = 1'b0;
    busyD   = 1'b0;
    doneD   = 1'b0;
    loadX   = 1'b0;
    loadH   = 1'b0;
    loadS   = 1'b0;
    hMode   = H_ADD;
    sel0    = M0_NONE;
    sel1    = M1_M0;
    sel2    = M2_R0;
    case (stateQ)
      IDLE: begin
        if (bus.start) stateD = LOADX;
      end
      LOADX: begin
        busyD = 1'b1;
        if (stepOk) begin
          loadX   = 1'b1;
          stateD  = MUL_A;
          cntLoad = 1'b1;
        end
      end
      MUL_A: begin
        busyD = 1'b1;
        sel0  = M0_A;
        sel1  = M1_M0;
        sel2  = M2_R0;
        hMode = H_MUL;
        if (holdDone && stepOk) begin
          loadH   = 1'b1;
          stateD  = ADD_B;
          cntLoad = 1'b1;
        end
      end
      ADD_B: begin
        busyD = 1'b1;
        sel0  = M0_B;
        sel1  = M1_R1;
        sel2  = M2_M0;
        hMode = H_ADD;
        if (holdDone && stepOk) begin
          loadH   = 1'b1;
          stateD  = MUL_X;
          cntLoad = 1'b1;
        end
      end
      MUL_X: begin
        busyD = 1'b1;
        sel0  = M0_NONE;
        sel1  = M1_R1;
        sel2  = M2_R0;
        hMode = H_MUL;
        if (holdDone && stepOk) begin
          loadH   = 1'b1;
          stateD  = ADD_C;
          cntLoad = 1'b1;
        end
      end
      ADD_C: begin
        busyD = 1'b1;
        sel0  = M0_C;
        sel1  = M1_R1;
        sel2  = M2_M0;
        hMode = H_ADD;
        if (holdDone && stepOk) begin
          loadS  = 1'b1;
          stateD = DONE;
        end
      end
      DONE: begin
        busyD  = 1'b1;
        doneD  = 1'b1;
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  assign bus.busy = busyD;
  assign bus.done = doneD;
  assign bus.LX   = loadX;
  assign bus.LH   = loadH;
  assign bus.LS   = loadS;
  assign bus.H    = hMode;
  assign bus.M0   = sel0;
  assign bus.M1   = sel1;
  assign bus.M2   = sel2;

endmodule

// File: tb/tb_bc_polinomio.sv
// Bench for bc_polinomio: two instances (OP_CYCLES=1 and 3), each paired with
// a behavioural BO model. Expected per-cycle outputs come from a schedule
// built from the state table; expected R2 is A*x*x+B*x+C.
module tb_bc_polinomio;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RST;

  bc_polinomio_if bus1 ();
  bc_polinomio_if bus3 ();

  bc_polinomio #(.OP_CYCLES(1)) dut1 (.clk(clk), .RST(RST), .bus(bus1.master));
  bc_polinomio #(.OP_CYCLES(3)) dut3 (.clk(clk), .RST(RST), .bus(bus3.master));

  int total = 0;
  int bad   = 0;

  logic [31:0] opA, opB, opC, opX;
  logic [31:0] r0a, r1a, r2a, r0b, r1b, r2b;

  // {busy, done, LX, LH, LS, H, M0, M1, M2}
  logic [11:0] obs1, obs3;
  assign obs1 = {bus1.busy, bus1.done, bus1.LX, bus1.LH, bus1.LS, bus1.H, bus1.M0, bus1.M1, bus1.M2};
  assign obs3 = {bus3.busy, bus3.done, bus3.LX, bus3.LH, bus3.LS, bus3.H, bus3.M0, bus3.M1, bus3.M2};

  localparam logic [11:0] STROBE_MASK = 12'h380;
  localparam logic [11:0] W_LOADX     = 12'b1_0_1_0_0_0_00_00_00;
  localparam logic [11:0] W_DONE      = 12'b1_1_0_0_0_0_00_00_00;
  localparam logic [11:0] W_PARKED_X  = 12'b1_0_0_0_0_0_00_00_00;

  // Behavioural BO: operand muxes and ALU
  function automatic logic [31:0] aluOut(logic [1:0] m0, logic [1:0] m1, logic [1:0] m2, logic h,
                                         logic [31:0] r0, logic [31:0] r1, logic [31:0] r2);
    logic [31:0] mo, a, b;
    case (m0)
      2'b01:   mo = opA;
      2'b10:   mo = opB;
      2'b11:   mo = opC;
      default: mo = 32'd0;
    endcase
    case (m1)
      2'b00:   a = mo;
      2'b01:   a = r0;
      2'b10:   a = r1;
      default: a = r2;
    endcase
    case (m2)
      2'b00:   b = r0;
      2'b01:   b = mo;
      2'b10:   b = r1;
      default: b = r2;
    endcase
    return h ? a * b : a + b;
  endfunction

  always @(posedge clk) begin
    if (bus1.LX) r0a <= opX;
    if (bus1.LH) r1a <= aluOut(bus1.M0, bus1.M1, bus1.M2, bus1.H, r0a, r1a, r2a);
    if (bus1.LS) r2a <= aluOut(bus1.M0, bus1.M1, bus1.M2, bus1.H, r0a, r1a, r2a);
  end

  always @(posedge clk) begin
    if (bus3.LX) r0b <= opX;
    if (bus3.LH) r1b <= aluOut(bus3.M0, bus3.M1, bus3.M2, bus3.H, r0b, r1b, r2b);
    if (bus3.LS) r2b <= aluOut(bus3.M0, bus3.M1, bus3.M2, bus3.H, r0b, r1b, r2b);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Expected output words, one per cycle, from LOADX through DONE
  logic [11:0] sched[$];

  task automatic buildSched(input int op);
    logic last;
    sched.delete();
    sched.push_back(W_LOADX);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < op; c++) begin
        last = (c == op - 1);
        case (s)
          0: sched.push_back({1'b1, 1'b0, 1'b0, last, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00});
          1: sched.push_back({1'b1, 1'b0, 1'b0, last, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01});
          2: sched.push_back({1'b1, 1'b0, 1'b0, last, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00});
          default: sched.push_back({1'b1, 1'b0, 1'b0, 1'b0, last, 1'b0, 2'b11, 2'b10, 2'b01});
        endcase
      end
    end
    sched.push_back(W_DONE);
  endtask

  task automatic runSeq(input int which, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] x, input logic [31:0] y,
                        input string tag);
    opA = a; opB = b; opC = c; opX = x;
    buildSched(which);
    @(negedge clk);
    if (which == 1) bus1.start = 1'b1;
    else bus3.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    for (int i = 0; i < sched.size(); i++) begin
      check($sformatf("%s_cyc%0d", tag, i), (which == 1) ? obs1 : obs3, sched[i]);
      @(posedge clk); #1;
    end
    check($sformatf("%s_idle", tag), (which == 1) ? obs1 : obs3, 12'd0);
    check($sformatf("%s_r2", tag), (which == 1) ? r2a : r2b, y);
  endtask

  typedef struct {
    logic [31:0] a, b, c, x, y;
  } vec_t;

  vec_t vt[8];

  initial begin
    int doneCnt, doneAt;
    RST = 1'b0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
`ifdef BC_STEP_EN
    bus1.step = 1'b1;
    bus3.step = 1'b1;
`endif
    opA = 0; opB = 0; opC = 0; opX = 0;

    vt[0] = '{a: 2, b: 3, c: 4, x: 5, y: 69};
    vt[1] = '{a: 1, b: 1, c: 1, x: 1, y: 3};
    vt[2] = '{a: 0, b: 0, c: 7, x: 9, y: 7};
    vt[3] = '{a: 3, b: 0, c: 0, x: 4, y: 48};
    for (int i = 4; i < 8; i++) begin
      vt[i].a = $urandom_range(0, 1000);
      vt[i].b = $urandom_range(0, 1000);
      vt[i].c = $urandom_range(0, 1000);
      vt[i].x = $urandom_range(0, 1000);
      vt[i].y = vt[i].a * vt[i].x * vt[i].x + vt[i].b * vt[i].x + vt[i].c;
    end

    // Reset and idle
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_out1", obs1, 12'd0);
      check("reset_out3", obs3, 12'd0);
    end
    @(negedge clk);
    RST = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("idle_out1", obs1, 12'd0);
      check("idle_out3", obs3, 12'd0);
    end

    // Table-driven full evaluations on both hold settings
    for (int i = 0; i < 8; i++) begin
      runSeq(1, vt[i].a, vt[i].b, vt[i].c, vt[i].x, vt[i].y, $sformatf("vec%0d_op1", i));
      runSeq(3, vt[i].a, vt[i].b, vt[i].c, vt[i].x, vt[i].y, $sformatf("vec%0d_op3", i));
    end

    // Start re-pulsed while busy: ignored, single done at the normal latency
    opA = 2; opB = 3; opC = 4; opX = 5;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    doneCnt = 0; doneAt = -1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      bus1.start = (k == 2);
      if (bus1.done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = k;
      end
    end
    bus1.start = 1'b0;
    check("busy_start_done_count", doneCnt, 1);
    check("busy_start_done_at", doneAt, 5);
    check("busy_start_r2", r2a, 69);

    // Start held high: next evaluation begins right after the IDLE cycle following DONE
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    doneAt = -1;
    for (int k = 1; k <= 20 && doneAt < 0; k++) begin
      @(posedge clk); #1;
      if (bus1.done) doneAt = k;
    end
    check("held_start_done_at", doneAt, 5);
    @(posedge clk); #1;
    check("held_start_idle", obs1, 12'd0);
    @(posedge clk); #1;
    check("held_start_reload", obs1, W_LOADX);
    bus1.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("held_start_r2", r2a, 69);

    // Reset asserted during MUL_X, then a fresh evaluation with x=1
    opA = 2; opB = 3; opC = 4; opX = 5;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_in_mulx", obs1, 12'b1_0_0_1_0_1_00_10_00);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_out1", obs1, 12'd0);
    check("midrst_out3", obs3, 12'd0);
    @(negedge clk);
    RST = 1'b1;
    runSeq(1, 2, 3, 4, 1, 9, "after_rst");

`ifdef BC_STEP_EN
    // Single-step: park in LOADX, then one strobe per step pulse
    opA = 2; opB = 3; opC = 4; opX = 5;
    buildSched(1);
    bus1.step = 1'b0;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    repeat (3) begin
      check("step_parked_loadx", obs1, W_PARKED_X);
      @(posedge clk); #1;
    end
    for (int p = 0; p < 5; p++) begin
      bus1.step = 1'b1;
      #1;
      check($sformatf("step_pulse%0d", p), obs1, sched[p]);
      @(posedge clk); #1;
      bus1.step = 1'b0;
      #1;
      check($sformatf("step_park%0d", p), obs1, sched[p + 1] & ~STROBE_MASK);
    end
    @(posedge clk); #1;
    check("step_idle", obs1, 12'd0);
    check("step_r2", r2a, 69);
    bus1.step = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
